// File: rtl/csr_pkg.sv
// Shared encodings for the CSR unit's available/busy/fault handshake:
// op codes, trap causes and the sequencer / handshake state enums.
package csr_pkg;

    localparam logic [2:0] CSR_OP_EXC  = 3'b000;
    localparam logic [2:0] CSR_OP_MRET = 3'b001;
    localparam logic [2:0] CSR_OP_RW   = 3'b101;
    localparam logic [2:0] CSR_OP_RS   = 3'b110;
    localparam logic [2:0] CSR_OP_RC   = 3'b111;

    // bit4 flags an interrupt, bits 3:0 carry the cause code
    localparam logic [11:0] CSR_CAUSE_EXT_INT = 12'h01B;
    localparam logic [11:0] CSR_CAUSE_SW_INT  = 12'h013;
    localparam logic [11:0] CSR_CAUSE_ILLEGAL = 12'h002;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ACTIVE,
        SEQ_RESP,
        SEQ_HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_ISSUE,
        HS_WAIT,
        HS_RELEASE
    } hs_state_t;

    function automatic logic is_csr_access(input logic [2:0] op);
        return (op == CSR_OP_RW) || (op == CSR_OP_RS) || (op == CSR_OP_RC);
    endfunction

    function automatic logic is_redirect_op(input logic [2:0] op);
        return (op == CSR_OP_EXC) || (op == CSR_OP_MRET);
    endfunction

endpackage

// File: rtl/csr_handshake.sv
// Initiator FSM for the CSR unit handshake: ISSUE -> WAIT -> RELEASE, done pulses on the last RELEASE cycle.
// Optional watchdog under CSR_SEQ_TIMEOUT_EN; a start during done chains straight back into ISSUE.
module csr_handshake
    import csr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        available,
    output logic        done,
    output logic        timeout,
    output logic [31:0] read_value,
    output logic        fault,
    input  logic        csr_busy,
    input  logic [31:0] csr_read_value,
    input  logic        csr_fault
);

    hs_state_t state;
    hs_state_t state_next;
    logic      release_armed;

`ifdef CSR_SEQ_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign timeout = (state != HS_IDLE) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Each state gets its own budget: the count restarts on every state entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= 16'd0;
        end else if ((state_next != state) || (state == HS_IDLE)) begin
            wd_cnt <= 16'd0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    logic [15:0] timeout_limit_unused;

    assign timeout_limit_unused = 16'(TIMEOUT_CYCLES);
    assign timeout              = 1'b0;
`endif

    assign available = (state == HS_ISSUE) || (state == HS_WAIT);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            HS_IDLE: begin
                if (start) state_next = HS_ISSUE;
            end
            HS_ISSUE: begin
                if (csr_busy) state_next = HS_WAIT;
            end
            HS_WAIT: begin
                if (!csr_busy) state_next = HS_RELEASE;
            end
            HS_RELEASE: begin
                // The unit's DONE pulse lands after our first RELEASE cycle
                if (release_armed && !csr_busy) begin
                    done       = 1'b1;
                    state_next = start ? HS_ISSUE : HS_IDLE;
                end
            end
            default: state_next = HS_IDLE;
        endcase
        if (timeout) begin
            state_next = HS_IDLE;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= HS_IDLE;
            release_armed <= 1'b0;
            read_value    <= 32'd0;
            fault         <= 1'b0;
        end else begin
            state         <= state_next;
            release_armed <= (state == HS_RELEASE) && (state_next == HS_RELEASE);
            if ((state == HS_WAIT) && !csr_busy) begin
                read_value <= csr_read_value;
                fault      <= csr_fault;
            end
        end
    end

endmodule

// File: rtl/csr_sequencer.sv
// CSR sequencer: takes decode requests / interrupts, drives the CSR unit, returns a 1-cycle response (>=6 cycles).
// req_ready only in IDLE and never while an interrupt is taken; optional watchdog under CSR_SEQ_TIMEOUT_EN.
module csr_sequencer
    import csr_pkg::*;
#(
    parameter logic [11:0] EXT_INT_CAUSE  = CSR_CAUSE_EXT_INT,
    parameter logic [11:0] SW_INT_CAUSE   = CSR_CAUSE_SW_INT,
    parameter logic [11:0] ILLEGAL_CAUSE  = CSR_CAUSE_ILLEGAL,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_addr_cause,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    input  logic        int_window,
    input  logic [31:0] int_pc,
    input  logic        ext_int_pending,
    input  logic        sw_int_pending,
    output logic        csr_available,
    output logic [2:0]  csr_op,
    output logic [11:0] csr_addr_exception,
    output logic [31:0] csr_write_value,
    input  logic [31:0] csr_read_value,
    input  logic        csr_busy,
    input  logic        csr_fault,
    output logic        rsp_valid,
    output logic        rsp_rd_write,
    output logic [31:0] rsp_rd_value,
    output logic        rsp_redirect,
    output logic [31:0] rsp_next_pc,
    output logic        rsp_trap,
    output logic        double_fault
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic        int_take;
    logic        accept;
    logic        retry;
    logic        finish;
    logic        halt_now;
    logic        hs_start;
    logic        hs_done;
    logic        hs_timeout;
    logic        hs_fault;
    logic [31:0] hs_read_value;
    logic [31:0] pc_q;
    logic        trap_q;

    csr_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_handshake (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (hs_start),
        .available      (csr_available),
        .done           (hs_done),
        .timeout        (hs_timeout),
        .read_value     (hs_read_value),
        .fault          (hs_fault),
        .csr_busy       (csr_busy),
        .csr_read_value (csr_read_value),
        .csr_fault      (csr_fault)
    );

    always_comb begin
        int_take   = (state == SEQ_IDLE) && int_window && (ext_int_pending || sw_int_pending);
        req_ready  = (state == SEQ_IDLE) && !int_take;
        accept     = req_valid && req_ready;
        // A faulting access becomes an illegal-instruction trap; a fault on any exception is fatal
        retry      = hs_done && hs_fault && !trap_q && (csr_op != CSR_OP_EXC);
        halt_now   = hs_timeout || (hs_done && hs_fault && !retry);
        finish     = hs_done && !hs_fault;
        hs_start   = accept || int_take || retry;
        rsp_valid  = (state == SEQ_RESP);
        state_next = state;
        case (state)
            SEQ_IDLE: begin
                if (accept || int_take) state_next = SEQ_ACTIVE;
            end
            SEQ_ACTIVE: begin
                if (halt_now)    state_next = SEQ_HALT;
                else if (finish) state_next = SEQ_RESP;
            end
            SEQ_RESP: state_next = SEQ_IDLE;
            SEQ_HALT: state_next = SEQ_HALT;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= SEQ_IDLE;
            csr_op             <= CSR_OP_EXC;
            csr_addr_exception <= 12'd0;
            csr_write_value    <= 32'd0;
            pc_q               <= 32'd0;
            trap_q             <= 1'b0;
            double_fault       <= 1'b0;
            rsp_rd_write       <= 1'b0;
            rsp_rd_value       <= 32'd0;
            rsp_redirect       <= 1'b0;
            rsp_next_pc        <= 32'd0;
            rsp_trap           <= 1'b0;
        end else begin
            state <= state_next;
            if (int_take) begin
                csr_op             <= CSR_OP_EXC;
                csr_addr_exception <= ext_int_pending ? EXT_INT_CAUSE : SW_INT_CAUSE;
                csr_write_value    <= int_pc;
                trap_q             <= 1'b0;
            end else if (accept) begin
                csr_op             <= req_op;
                csr_addr_exception <= req_addr_cause;
                csr_write_value    <= (req_op == CSR_OP_EXC) ? req_pc : req_wdata;
                pc_q               <= req_pc;
                trap_q             <= 1'b0;
            end else if (retry) begin
                csr_op             <= CSR_OP_EXC;
                csr_addr_exception <= ILLEGAL_CAUSE;
                csr_write_value    <= pc_q;
                trap_q             <= 1'b1;
            end
            if (halt_now) begin
                double_fault <= 1'b1;
            end
            if ((state == SEQ_ACTIVE) && finish) begin
                rsp_rd_write <= !trap_q && is_csr_access(csr_op);
                rsp_rd_value <= hs_read_value;
                rsp_redirect <= trap_q || is_redirect_op(csr_op);
                rsp_next_pc  <= hs_read_value;
                rsp_trap     <= trap_q;
            end
        end
    end

endmodule

// File: tb/tb_csr_sequencer.sv
// Bench for csr_sequencer: a behavioural CSR-unit stub on the handshake plus an ISA-level model of
// the CSR file that predicts every response; watchdog checks compile in with CSR_SEQ_TIMEOUT_EN.
module tb_csr_sequencer;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [11:0] req_addr_cause = 12'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] req_pc = 32'd0;
    logic        int_window = 1'b0;
    logic [31:0] int_pc = 32'd0;
    logic        ext_int_pending;
    logic        sw_int_pending;
    logic        csr_available;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr_exception;
    logic [31:0] csr_write_value;
    logic [31:0] csr_read_value;
    logic        csr_busy;
    logic        csr_fault;
    logic        rsp_valid;
    logic        rsp_rd_write;
    logic [31:0] rsp_rd_value;
    logic        rsp_redirect;
    logic [31:0] rsp_next_pc;
    logic        rsp_trap;
    logic        double_fault;

    always #5 clk = ~clk;

    csr_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_addr_cause     (req_addr_cause),
        .req_wdata          (req_wdata),
        .req_pc             (req_pc),
        .int_window         (int_window),
        .int_pc             (int_pc),
        .ext_int_pending    (ext_int_pending),
        .sw_int_pending     (sw_int_pending),
        .csr_available      (csr_available),
        .csr_op             (csr_op),
        .csr_addr_exception (csr_addr_exception),
        .csr_write_value    (csr_write_value),
        .csr_read_value     (csr_read_value),
        .csr_busy           (csr_busy),
        .csr_fault          (csr_fault),
        .rsp_valid          (rsp_valid),
        .rsp_rd_write       (rsp_rd_write),
        .rsp_rd_value       (rsp_rd_value),
        .rsp_redirect       (rsp_redirect),
        .rsp_next_pc        (rsp_next_pc),
        .rsp_trap           (rsp_trap),
        .double_fault       (double_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // CSR file slots: 0 mstatus, 1 mie, 2 mtvec (read-only), 3 mepc, 4 mcause; 7 = no such CSR
    function automatic logic [2:0] csr_idx(input logic [11:0] a);
        case (a)
            12'h300: return 3'd0;
            12'h304: return 3'd1;
            12'h305: return 3'd2;
            12'h341: return 3'd3;
            12'h342: return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] mcause_of(input logic [11:0] cause);
        return cause[4] ? {1'b1, 27'd0, cause[3:0]} : {28'd0, cause[3:0]};
    endfunction

    function automatic logic [31:0] new_val(input logic [2:0] op, input logic [31:0] old, input logic [31:0] wd);
        case (op)
            3'b101:  return wd;
            3'b110:  return old | wd;
            3'b111:  return old & ~wd;
            default: return old;
        endcase
    endfunction

    // ---------------- CSR unit stub ----------------
    typedef enum logic [1:0] {ST_IDLE, ST_WORK, ST_RESULT, ST_DONE} stub_st_t;
    stub_st_t    st;
    int          stub_lat = 1;
    int          cnt;
    bit          stub_hang = 1'b0;
    bit          stub_mute = 1'b0;
    bit          fault_exc = 1'b0;
    logic        ext_line = 1'b0;
    logic        sw_line = 1'b0;
    logic [2:0]  l_op;
    logic [11:0] l_addr;
    logic [31:0] l_wv;
    logic [2:0]  stub_idx;
    logic [31:0] stub_csr [8];
    logic [31:0] model_csr [8];

    always_comb stub_idx = csr_idx(l_addr);
    assign ext_int_pending = ext_line & stub_csr[1][11] & stub_csr[0][3];
    assign sw_int_pending  = sw_line  & stub_csr[1][3]  & stub_csr[0][3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st             <= ST_IDLE;
            csr_busy       <= 1'b0;
            csr_fault      <= 1'b0;
            csr_read_value <= 32'd0;
            cnt            <= 0;
            l_op           <= 3'd0;
            l_addr         <= 12'd0;
            l_wv           <= 32'd0;
            for (int i = 0; i < 8; i++) stub_csr[i] <= (i == 2) ? 32'h10 : 32'd0;
        end else begin
            case (st)
                ST_IDLE: if (csr_available && !stub_mute) begin
                    st       <= ST_WORK;
                    csr_busy <= 1'b1;
                    cnt      <= stub_lat - 1;
                    l_op     <= csr_op;
                    l_addr   <= csr_addr_exception;
                    l_wv     <= csr_write_value;
                end
                ST_WORK: if (!stub_hang) begin
                    if (cnt == 0) begin
                        st       <= ST_RESULT;
                        csr_busy <= 1'b0;
                        case (l_op)
                            3'b000: begin
                                csr_fault      <= fault_exc;
                                csr_read_value <= stub_csr[2];
                                if (!fault_exc) begin
                                    stub_csr[3] <= l_wv;
                                    stub_csr[4] <= mcause_of(l_addr);
                                end
                            end
                            3'b001: begin
                                csr_fault      <= 1'b0;
                                csr_read_value <= stub_csr[3];
                            end
                            3'b101, 3'b110, 3'b111: begin
                                if (stub_idx > 3'd4 || stub_idx == 3'd2) begin
                                    csr_fault      <= 1'b1;
                                    csr_read_value <= 32'd0;
                                end else begin
                                    csr_fault          <= 1'b0;
                                    csr_read_value     <= stub_csr[stub_idx];
                                    stub_csr[stub_idx] <= new_val(l_op, stub_csr[stub_idx], l_wv);
                                end
                            end
                            default: csr_fault <= 1'b1;
                        endcase
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
                ST_RESULT: begin
                    st        <= ST_DONE;
                    csr_busy  <= 1'b1;
                    csr_fault <= 1'b0;
                end
                default: begin
                    st       <= ST_IDLE;
                    csr_busy <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_csr[i] = (i == 2) ? 32'h10 : 32'd0;
    endtask

    task automatic predict(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                           input logic [31:0] pc, output bit trap, output bit redir,
                           output bit rdw, output logic [31:0] val);
        logic [2:0] k;
        k = csr_idx(a);
        trap = 0; redir = 0; rdw = 0; val = 32'd0;
        if ((op == 3'b101 || op == 3'b110 || op == 3'b111) && k <= 3'd4 && k != 3'd2) begin
            rdw = 1; val = model_csr[k]; model_csr[k] = new_val(op, model_csr[k], wd);
        end else if (op == 3'b000) begin
            redir = 1; val = model_csr[2]; model_csr[3] = pc; model_csr[4] = mcause_of(a);
        end else if (op == 3'b001) begin
            redir = 1; val = model_csr[3];
        end else begin
            trap = 1; redir = 1; val = model_csr[2]; model_csr[3] = pc; model_csr[4] = 32'd2;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic accept_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr_cause = a; req_wdata = wd; req_pc = pc;
        #1;
        while (!req_ready && guard < 50) begin
            @(negedge clk); #1; guard++;
        end
        if (!req_ready) check_eq("accept_stall", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk); lat++;
            if (rsp_valid) break;
        end
        check_eq("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic txn(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, input int exp_lat);
        bit trap, redir, rdw;
        logic [31:0] val;
        int lat;
        predict(op, a, wd, pc, trap, redir, rdw, val);
        accept_req(op, a, wd, pc);
        wait_rsp(lat);
        if (exp_lat > 0) check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("rsp_trap", 32'(rsp_trap), 32'(trap));
        check_eq("rsp_redirect", 32'(rsp_redirect), 32'(redir));
        check_eq("rsp_rd_write", 32'(rsp_rd_write), 32'(rdw));
        if (rdw)   check_eq("rsp_rd_value", rsp_rd_value, val);
        if (redir) check_eq("rsp_next_pc", rsp_next_pc, val);
        @(negedge clk);
        check_eq("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        model_reset();
    endtask

    logic [2:0]  op_tab   [6] = '{3'b000, 3'b001, 3'b101, 3'b110, 3'b111, 3'b010};
    logic [11:0] addr_tab [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h7FF};

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        bit saw_rsp;
        logic [11:0] cause;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_req_ready", 32'(req_ready), 32'd1);
        check_eq("reset_available", 32'(csr_available), 32'd0);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_double_fault", 32'(double_fault), 32'd0);
        check_eq("reset_csr_op", 32'(csr_op), 32'd0);
        reset_n = 1'b1;

        // CSRRW mie, then a faulting CSRRS on read-only mtvec
        txn(3'b101, 12'h304, 32'h808, 32'h1000, 6);
        check_eq("mie_written", stub_csr[1], 32'h808);
        txn(3'b110, 12'h305, 32'h1, 32'h1004, 0);
        check_eq("trap_mepc", stub_csr[3], 32'h1004);
        check_eq("trap_mcause", stub_csr[4], 32'd2);
        txn(3'b101, 12'h300, 32'h8, 32'h1008, 6);

        // interrupts at a boundary: ext+req, ext+sw, sw only
        for (int t = 0; t < 3; t++) begin
            cause = (t != 2) ? 12'h01B : 12'h013;
            @(negedge clk);
            ext_line = (t != 2); sw_line = (t != 0); int_window = 1'b1;
            int_pc = $urandom & 32'hFFFF_FFFC;
            req_valid = 1'b1; req_op = 3'b101; req_addr_cause = 12'h304; req_wdata = 32'h0;
            #1;
            check_eq("int_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            int_window = 1'b0; ext_line = 1'b0; sw_line = 1'b0; req_valid = 1'b0;
            @(negedge clk);
            check_eq("int_csr_op", 32'(csr_op), 32'd0);
            check_eq("int_cause", 32'(csr_addr_exception), 32'(cause));
            check_eq("int_write_value", csr_write_value, int_pc);
            check_eq("int_available", 32'(csr_available), 32'd1);
            model_csr[3] = int_pc; model_csr[4] = mcause_of(cause);
            wait_rsp(lat);
            check_eq("int_redirect", 32'(rsp_redirect), 32'd1);
            check_eq("int_next_pc", rsp_next_pc, 32'h10);
            check_eq("int_rd_write", 32'(rsp_rd_write), 32'd0);
            check_eq("int_mcause", stub_csr[4], model_csr[4]);
        end
        check_eq("ext_mcause_value", mcause_of(12'h01B), 32'h8000_000B);

        // exception then MRET returns to the exception PC
        txn(3'b000, 12'h00B, 32'h0, 32'h200, 6);
        txn(3'b001, 12'h000, 32'h0, 32'h300, 6);
        check_eq("mret_target", rsp_next_pc, 32'h200);

        for (int i = 0; i < 40; i++) begin
            stub_lat = $urandom_range(1, 3);
            txn(op_tab[$urandom_range(0, 5)], addr_tab[$urandom_range(0, 5)],
                $urandom, $urandom & 32'hFFFF_FFFC, 0);
        end
        stub_lat = 1;
        for (int i = 0; i < 5; i++) check_eq("csr_state", stub_csr[i], model_csr[i]);

        // reset while waiting on a hung CSR unit drops available asynchronously
        stub_hang = 1'b1;
        accept_req(3'b101, 12'h304, 32'h5, 32'h400);
        repeat (4) @(negedge clk);
        check_eq("avail_in_wait", 32'(csr_available), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("avail_async_reset", 32'(csr_available), 32'd0);
        check_eq("ready_async_reset", 32'(req_ready), 32'd1);
        stub_hang = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        model_reset();

        // fault on an exception halts until reset
        fault_exc = 1'b1;
        accept_req(3'b000, 12'h00B, 32'h0, 32'h500);
        saw_rsp = 0; lat = 0;
        while (!double_fault && lat < 40) begin
            @(negedge clk); lat++;
            if (rsp_valid) saw_rsp = 1;
        end
        check_eq("double_fault_set", 32'(double_fault), 32'd1);
        check_eq("double_fault_no_rsp", 32'(saw_rsp), 32'd0);
        fault_exc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("halt_req_ready", 32'(req_ready), 32'd0);
        end
        check_eq("halt_available", 32'(csr_available), 32'd0);
        pulse_reset();
        check_eq("df_cleared", 32'(double_fault), 32'd0);
        check_eq("ready_after_reset", 32'(req_ready), 32'd1);
        txn(3'b101, 12'h304, 32'h3, 32'h600, 6);

`ifdef CSR_SEQ_TIMEOUT_EN
        stub_mute = 1'b1;
        accept_req(3'b101, 12'h304, 32'h1, 32'h700);
        lat = 0;
        while (!double_fault && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check_eq("timeout_cycles", 32'(lat), 32'd16);
        check_eq("timeout_available", 32'(csr_available), 32'd0);
        stub_mute = 1'b0;
        pulse_reset();
        check_eq("timeout_df_cleared", 32'(double_fault), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_sequencer.md
Name: csr_sequencer

Overview:
- Initiator side of the CSR unit's available/busy/fault handshake.
- Accepts SYSTEM-instruction requests from decode and interrupt-take requests at instruction boundaries, and drives op/addr_exception/write_value to the CSR unit.
- Collects read_value and fault, and returns a single-cycle response with rd writeback and PC redirect.
- Converts a CSR access fault into an illegal-instruction exception issued automatically to the CSR unit.

Parameters:
- EXT_INT_CAUSE, 12'h01B, cause issued for an external interrupt (bit4 = interrupt, code 11).
- SW_INT_CAUSE, 12'h013, cause issued for a software interrupt (code 3).
- ILLEGAL_CAUSE, 12'h002, cause issued when a non-exception op faults.
- TIMEOUT_CYCLES, 16, watchdog limit; used only with CSR_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_op  in  3  CSR op encoding: 000 exception, 001 MRET, 101 RW, 110 RS, 111 RC; others invalid.
- req_addr_cause  in  12  CSR address or exception cause.
- req_wdata  in  32  CSR write operand.
- req_pc  in  32  PC of the requesting instruction.
- int_window  in  1  core is at an instruction boundary.
- int_pc  in  32  resume PC for an interrupt.
- ext_int_pending  in  1  from the CSR unit.
- sw_int_pending  in  1  from the CSR unit.
- csr_available  out  1  to CSR unit.
- csr_op  out  3  to CSR unit.
- csr_addr_exception  out  12  to CSR unit.
- csr_write_value  out  32  to CSR unit.
- csr_read_value  in  32  from CSR unit.
- csr_busy  in  1  from CSR unit.
- csr_fault  in  1  from CSR unit.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rd_write  out  1  write rsp_rd_value to rd.
- rsp_rd_value  out  32  old CSR value.
- rsp_redirect  out  1  core must jump to rsp_next_pc.
- rsp_next_pc  out  32  redirect target.
- rsp_trap  out  1  response resulted from an illegal-instruction conversion.
- double_fault  out  1  sticky; sequencer halted.

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready, which is combinational and therefore 1 in IDLE while int_take is low.
- int_take = IDLE & int_window & (ext_int_pending | sw_int_pending).
  - External beats software.
  - Interrupt beats req_valid in the same cycle; req_ready = IDLE & ~int_take.
- Latch on accept or int_take:
  - Request: csr_op = req_op, csr_addr_exception = req_addr_cause.
  - csr_write_value = req_pc for op 000, else req_wdata.
  - Interrupt: op 000, cause EXT/SW_INT_CAUSE, write_value = int_pc.
- ISSUE:
  - csr_available = 1.
  - Go to WAIT when csr_busy sampled 1.
- WAIT: on csr_busy sampled 0:
  - Capture csr_read_value and csr_fault (valid only this cycle).
  - Deassert csr_available and go to RELEASE.
- RELEASE:
  - csr_available held 0.
  - CSR unit re-raises busy for one cycle (DONE state); exit when csr_busy sampled 0, at least 2 cycles after entry.
  - Next state RESP or ISSUE(trap).
- Fault handling:
  - Fault on a non-000 op: reload op 000, cause ILLEGAL_CAUSE, write_value = latched req_pc, set trap flag, go to ISSUE.
  - Fault on op 000, or on the trap re-issue: go to HALT and set double_fault. HALT exits only on reset.
- RESP: one cycle, rsp_valid = 1, then IDLE.
  - CSR ok: rd_write = 1, rd_value = read_value, redirect = 0.
  - MRET or exception/interrupt: redirect = 1, next_pc = read_value, rd_write = 0.
  - Trap: redirect = 1, next_pc = handler read_value, rd_write = 0, rsp_trap = 1.
- rsp_* fields hold their last value outside RESP; consumers qualify them with rsp_valid.
- Minimum latency accept→rsp_valid: 1 (latch) + 2 (ISSUE/WAIT) + 2 (RELEASE) + RESP. Issue to idle CSR unit: 6 cycles; trap path adds 4.
- Reset mid-operation: returns to IDLE immediately with available = 0. The CSR unit is reset by the same reset_n.

Optional Feature:
- CSR_SEQ_TIMEOUT_EN defined: counter runs in ISSUE/WAIT/RELEASE.
  - Reaching TIMEOUT_CYCLES enters HALT with double_fault = 1 and csr_available = 0.
  - Counter clears on each state entry.
- Undefined: no counter; the sequencer waits indefinitely.

Decomposition:
- Shared package csr_pkg:
  - op encodings (CSR_OP_EXC, CSR_OP_MRET, CSR_OP_RW/RS/RC).
  - cause constants.
  - sequencer state enum.
- Sub-module csr_handshake: ISSUE/WAIT/RELEASE initiator FSM with a start/done/fault interface; reusable by other CSR-unit clients.

Test Plan:
- CSRRW 0x304, wdata 0x808, CSR read 0x0 → rsp_valid at accept+6, rd_write = 1, rd_value = 0, redirect = 0; then mie = 0x808.
- CSRRS 0x305, wdata 0x1 → fault converted; rsp_trap = 1, redirect = 1, next_pc = 0x10, rd_write = 0; mepc = req_pc, mcause = 2.
- mie = 0x808, mstatus.MIE = 1, external interrupt pending, int_window = 1, req_valid = 1 same cycle → req_ready = 0, issue cause 0x01B; next_pc = 0x10; mcause = 0x8000000B.
- Exception then MRET with pc 0x200 → MRET rsp next_pc = 0x200.
- Stub CSR faulting on op 000 → double_fault = 1, req_ready stays 0 until reset_n pulse.
- With CSR_SEQ_TIMEOUT_EN: stub never raises busy → double_fault at TIMEOUT_CYCLES after ISSUE entry; reset mid-WAIT → available = 0 asynchronously.
